tensor_core_result_writeback: RTL and testbench
===============================================

Name: tensor_core_result_writeback

Overview:
- Downstream stage of the 3x3 tensor core. Collects the row-major stream of nine signed result elements produced by one matrix operation (multiply, add or ReLU).
- Packs the elements into pairs and writes them to the register file through its dual write port, using a valid/ready handshake.
- Pair writes overlap with collection: a pair is issued as soon as both of its elements have arrived.

Parameters:
- DATA_WIDTH, 8, width of one signed matrix element.
- ADDR_WIDTH, 5, register file address width.

Ports:
- clock_in  input  1  system clock; all logic on posedge.
- reset_n_in  input  1  synchronous, active-low reset.
- start_in  input  1  begin a new result capture; sampled only in IDLE.
- base_address_in  input  ADDR_WIDTH  destination address of element 0; latched on accepted start.
- element_valid_in  input  1  element_in carries the next row-major result element.
- element_in  input  DATA_WIDTH  signed result element.
- write_enable_out  output  1  write request valid.
- write_ready_in  input  1  register file accepts the write on this edge.
- write_address_out[2]  output  2 x ADDR_WIDTH  lane addresses.
- write_data_out[2]  output  2 x DATA_WIDTH  lane data.
- write_lane_mask_out  output  2  per-lane write enable; bit0 = lane 0.
- busy_out  output  1  high in COLLECT.
- done_out  output  1  one-cycle pulse after the final write is accepted.
- error_out  output  1  sticky; an element was dropped.

Behaviour:
- Reset (reset_n_in=0 at posedge): state=IDLE, all outputs 0, element count=0, pair index=0, error_out=0. The buffer contents need not be cleared. Reset wins over all other inputs, including reset mid-collection or mid-handshake; any pending write is abandoned.
- States: IDLE, COLLECT, DONE.
- IDLE:
  - start_in=1 -> COLLECT. Latch base address; clear count, pair index and error_out.
  - An element_valid_in in the start cycle is ignored and does not set error.
  - An element_valid_in in IDLE without start sets error_out.
- COLLECT, capture:
  - element_valid_in=1 with count<9: store element_in at buffer[count]; count++.
  - element_valid_in=1 with count=9: element dropped; error_out <= 1.
- COLLECT, write issue:
  - Pair k (k=0..4) covers elements 2k and 2k+1; pair 4 covers element 8 only.
  - Pair k<4 is issuable when count >= 2k+2. Pair 4 is issuable when count=9.
  - While pair k is issuable, drive write_enable_out=1 and:
    - write_address_out[0] = base+2k, write_address_out[1] = base+2k+1, addition modulo 2^ADDR_WIDTH (wraps).
    - write_data_out[0] = buffer[2k], write_data_out[1] = buffer[2k+1].
    - write_lane_mask_out = 2'b11; for pair 4 it is 2'b01, with lane-1 address and data driven to 0.
  - All write outputs are registered and update one cycle after the enabling element is captured. First write_enable_out rises the cycle after element 1 is captured.
  - Handshake: when write_enable_out=1 and write_ready_in=1 at a posedge, pair k is accepted. The pair index increments and the next pair is presented the following cycle if issuable; otherwise write_enable_out drops.
  - Address, data and mask remain stable while write_enable_out=1 and write_ready_in=0. write_enable_out never drops without acceptance, except on reset.
  - A new element arriving during a stall is captured normally; it never alters the pair being presented.
- Completion: acceptance of pair 4 -> DONE. write_enable_out=0 and done_out=1 for exactly one cycle, then IDLE. busy_out=0 in DONE.
- No start is accepted while in COLLECT or DONE.
- Data passes through unmodified, with no saturation or sign change. The upstream core has already truncated its results to DATA_WIDTH.
- Minimum latency, start to done with back-to-back elements and write_ready_in tied 1:
  - start edge, then 9 element edges, then the pair-4 write edge, then the DONE cycle.
  - done_out is high in the 11th cycle after the start edge.

Test Plan:
- Back-to-back stream: base=4, elements 1..9 on consecutive cycles, ready=1 -> five writes: (4,5)=(1,2), (6,7)=(3,4), (8,9)=(5,6), (10,11)=(7,8), (12)=9 with mask 01. done_out pulses once; error_out=0.
- Backpressure: ready held 0 for 3 cycles on pair 1, with data -1,-128,127,0,... -> addresses and data stable throughout; elements 4..8 still captured. Pairs complete in order with values unchanged; done_out follows the last accept.
- Gapped input: one element every 4 cycles -> each pair's write_enable_out rises exactly one cycle after its second element. write_enable_out is low between pairs.
- Overflow and stray input: 10th element_valid_in in COLLECT, and a valid in IDLE without start -> error_out=1 and stays set. Buffer and writes are unaffected. The next start clears error_out.
- Address wrap: base=30 -> pair 0 writes 30,31; pair 1 writes 0,1; pair 4 writes address 6, lane 0 only.
- Reset mid-operation: reset_n_in=0 while pair 2 stalls -> the next cycle shows all outputs 0 and state IDLE. A fresh start completes a full nine-element capture correctly.

Source files
------------

// File: rtl/tensor_core_result_writeback.sv
// Result writeback stage of the 3x3 tensor core: gathers nine row-major elements and
// writes them to the register file as lane pairs while collection is still under way.
module tensor_core_result_writeback #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                         clock_in,
  input  logic                         reset_n_in,
  input  logic                         start_in,
  input  logic [ADDR_WIDTH-1:0]        base_address_in,
  input  logic                         element_valid_in,
  input  logic signed [DATA_WIDTH-1:0] element_in,
  output logic                         write_enable_out,
  input  logic                         write_ready_in,
  output logic [ADDR_WIDTH-1:0]        write_address_out [2],
  output logic [DATA_WIDTH-1:0]        write_data_out [2],
  output logic [1:0]                   write_lane_mask_out,
  output logic                         busy_out,
  output logic                         done_out,
  output logic                         error_out
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_COLLECT = 2'd1, ST_DONE = 2'd2} state_t;

  state_t                state_r;
  logic [3:0]            count_r;
  logic [2:0]            pair_r;
  logic [ADDR_WIDTH-1:0] base_r;
  logic [DATA_WIDTH-1:0] buffer_r [9];
  logic                  write_enable_r, busy_r, done_r, error_r;
  logic [ADDR_WIDTH-1:0] address_r [2];
  logic [DATA_WIDTH-1:0] data_r [2];
  logic [1:0]            mask_r;

  logic                  capture_s, overflow_s, accept_s, hold_s, issue_s, last_pair_s;
  logic [3:0]            count_next_s, idx0_s, idx1_s;
  logic [2:0]            pair_next_s;
  logic [DATA_WIDTH-1:0] data0_s, data1_s;

  // Pairs 0..3 need both elements; the odd final pair only needs element 8.
  function automatic logic pair_issuable(input logic [2:0] pair, input logic [3:0] count);
    if (pair < 3'd4) begin
      return count >= ({pair, 1'b0} + 4'd2);
    end else if (pair == 3'd4) begin
      return count == 4'd9;
    end else begin
      return 1'b0;
    end
  endfunction

  assign capture_s    = (state_r == ST_COLLECT) && element_valid_in && (count_r < 4'd9);
  assign overflow_s   = (state_r == ST_COLLECT) && element_valid_in && (count_r == 4'd9);
  assign count_next_s = capture_s ? count_r + 4'd1 : count_r;
  assign accept_s     = write_enable_r && write_ready_in;
  assign hold_s       = write_enable_r && !write_ready_in;
  assign pair_next_s  = accept_s ? pair_r + 3'd1 : pair_r;
  assign issue_s      = (state_r == ST_COLLECT) && !hold_s && pair_issuable(pair_next_s, count_next_s);
  assign last_pair_s  = (pair_next_s == 3'd4);
  assign idx0_s       = {pair_next_s, 1'b0};
  assign idx1_s       = idx0_s + 4'd1;

  // Lane data for the next pair, bypassing the element being captured this cycle.
  always_comb begin
    data0_s = {DATA_WIDTH{1'b0}};
    data1_s = {DATA_WIDTH{1'b0}};
    if (capture_s && (idx0_s == count_r)) begin
      data0_s = element_in;
    end else if (idx0_s < 4'd9) begin
      data0_s = buffer_r[idx0_s];
    end else begin
      data0_s = {DATA_WIDTH{1'b0}};
    end
    if (last_pair_s) begin
      data1_s = {DATA_WIDTH{1'b0}};
    end else if (capture_s && (idx1_s == count_r)) begin
      data1_s = element_in;
    end else if (idx1_s < 4'd9) begin
      data1_s = buffer_r[idx1_s];
    end else begin
      data1_s = {DATA_WIDTH{1'b0}};
    end
  end

  // Control FSM, element buffer and registered write port.
  always_ff @(posedge clock_in) begin
    if (!reset_n_in) begin
      state_r              <= ST_IDLE;
      count_r              <= 4'd0;
      pair_r               <= 3'd0;
      base_r               <= {ADDR_WIDTH{1'b0}};
      write_enable_r       <= 1'b0;
      busy_r               <= 1'b0;
      done_r               <= 1'b0;
      error_r              <= 1'b0;
      address_r[0]         <= {ADDR_WIDTH{1'b0}};
      address_r[1]         <= {ADDR_WIDTH{1'b0}};
      data_r[0]            <= {DATA_WIDTH{1'b0}};
      data_r[1]            <= {DATA_WIDTH{1'b0}};
      mask_r               <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r         <= 1'b0;
          write_enable_r <= 1'b0;
          if (start_in) begin
            state_r <= ST_COLLECT;
            base_r  <= base_address_in;
            count_r <= 4'd0;
            pair_r  <= 3'd0;
            error_r <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            busy_r <= 1'b0;
            if (element_valid_in) begin
              error_r <= 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          if (capture_s) begin
            buffer_r[count_r] <= element_in;
          end
          if (overflow_s) begin
            error_r <= 1'b1;
          end
          count_r <= count_next_s;
          pair_r  <= pair_next_s;
          // A stalled pair keeps its address, data and mask untouched.
          if (!hold_s) begin
            write_enable_r <= issue_s;
            if (issue_s) begin
              address_r[0] <= base_r + ADDR_WIDTH'(idx0_s);
              address_r[1] <= last_pair_s ? {ADDR_WIDTH{1'b0}} : base_r + ADDR_WIDTH'(idx1_s);
              data_r[0]    <= data0_s;
              data_r[1]    <= data1_s;
              mask_r       <= last_pair_s ? 2'b01 : 2'b11;
            end else begin
              address_r[0] <= {ADDR_WIDTH{1'b0}};
              address_r[1] <= {ADDR_WIDTH{1'b0}};
              data_r[0]    <= {DATA_WIDTH{1'b0}};
              data_r[1]    <= {DATA_WIDTH{1'b0}};
              mask_r       <= 2'b00;
            end
          end
          if (accept_s && (pair_r == 3'd4)) begin
            state_r        <= ST_DONE;
            done_r         <= 1'b1;
            busy_r         <= 1'b0;
            write_enable_r <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r        <= ST_IDLE;
          done_r         <= 1'b0;
          busy_r         <= 1'b0;
          write_enable_r <= 1'b0;
        end
        default: begin
          state_r        <= ST_IDLE;
          done_r         <= 1'b0;
          busy_r         <= 1'b0;
          write_enable_r <= 1'b0;
        end
      endcase
    end
  end

  assign write_enable_out     = write_enable_r;
  assign write_address_out[0] = address_r[0];
  assign write_address_out[1] = address_r[1];
  assign write_data_out[0]    = data_r[0];
  assign write_data_out[1]    = data_r[1];
  assign write_lane_mask_out  = mask_r;
  assign busy_out             = busy_r;
  assign done_out             = done_r;
  assign error_out            = error_r;

endmodule

// File: tb/tb_tensor_core_result_writeback.sv
// Randomized bench for tensor_core_result_writeback; accepted writes are compared against
// a pair list built directly from the base address and the element values.
module tb_tensor_core_result_writeback;

  logic       clock_in = 1'b0;
  logic       reset_n_in = 1'b0;
  logic       start_in = 1'b0;
  logic [4:0] base_address_in = 5'd0;
  logic       element_valid_in = 1'b0;
  logic [7:0] element_in = 8'd0;
  logic       write_enable_out;
  logic       write_ready_in = 1'b0;
  logic [4:0] write_address_out [2];
  logic [7:0] write_data_out [2];
  logic [1:0] write_lane_mask_out;
  logic       busy_out, done_out, error_out;

  tensor_core_result_writeback #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .clock_in(clock_in), .reset_n_in(reset_n_in), .start_in(start_in),
    .base_address_in(base_address_in), .element_valid_in(element_valid_in),
    .element_in(element_in), .write_enable_out(write_enable_out),
    .write_ready_in(write_ready_in), .write_address_out(write_address_out),
    .write_data_out(write_data_out), .write_lane_mask_out(write_lane_mask_out),
    .busy_out(busy_out), .done_out(done_out), .error_out(error_out)
  );

  always #5 clock_in = ~clock_in;

  int errors = 0;
  int checks = 0;

  logic [7:0] elems [10];
  int         elem_edge [10];
  logic [4:0] obs_a0 [$], obs_a1 [$];
  logic [7:0] obs_d0 [$], obs_d1 [$];
  logic [1:0] obs_m [$];
  int         rise_q [$];
  logic [4:0] exp_a0 [5], exp_a1 [5];
  logic [7:0] exp_d0 [5], exp_d1 [5];
  logic [1:0] exp_m [5];
  int         unstable, done_cnt, done_at;
  bit         timed_out;
  logic       first_err, after_err, after_busy, after_wen;

  // Reference: pair k lands at base+2k / base+2k+1 (mod 32); the ninth element goes alone.
  task automatic build_expected(input int base);
    for (int k = 0; k < 5; k++) begin
      exp_a0[k] = 5'((base + 2 * k) % 32);
      exp_a1[k] = (k < 4) ? 5'((base + 2 * k + 1) % 32) : 5'd0;
      exp_d0[k] = elems[2 * k];
      exp_d1[k] = (k < 4) ? elems[2 * k + 1] : 8'd0;
      exp_m[k]  = (k < 4) ? 2'b11 : 2'b01;
    end
  endtask

  task automatic random_elems();
    for (int i = 0; i < 10; i++) elems[i] = 8'($urandom_range(255));
  endtask

  // Runs one capture and records every accepted write, rise times and stall stability.
  task automatic drive_op(input logic [4:0] base, input int n_elems, input int gap,
                          input int ready_pct, input int stall_pair, input int stall_len,
                          input bit start_valid);
    int e, cyc, gap_cnt, accepted, stall_left;
    logic p_wen, p_rdy, rdy;
    logic [4:0] p_a0, p_a1;
    logic [7:0] p_d0, p_d1;
    logic [1:0] p_m;
    obs_a0.delete(); obs_a1.delete(); obs_d0.delete(); obs_d1.delete(); obs_m.delete();
    rise_q.delete();
    unstable = 0; done_cnt = 0; done_at = -1; timed_out = 1'b1;
    @(negedge clock_in);
    start_in = 1'b1; base_address_in = base; element_valid_in = start_valid;
    element_in = 8'hA5; write_ready_in = 1'b1;
    @(posedge clock_in);
    cyc = 0; e = 0; gap_cnt = 0; accepted = 0; stall_left = stall_len;
    p_wen = 1'b0; p_rdy = 1'b1; p_a0 = 5'd0; p_a1 = 5'd0; p_d0 = 8'd0; p_d1 = 8'd0; p_m = 2'b00;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock_in);
      if (i == 0) first_err = error_out;
      if (write_enable_out && !p_wen) rise_q.push_back(cyc);
      if (p_wen && !p_rdy && (!write_enable_out || write_address_out[0] !== p_a0 ||
          write_address_out[1] !== p_a1 || write_data_out[0] !== p_d0 ||
          write_data_out[1] !== p_d1 || write_lane_mask_out !== p_m)) unstable++;
      if (done_out) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (done_at >= 0 && !done_out) begin
        after_err = error_out; after_busy = busy_out; after_wen = write_enable_out;
        timed_out = 1'b0;
        break;
      end
      p_wen = write_enable_out; p_a0 = write_address_out[0]; p_a1 = write_address_out[1];
      p_d0 = write_data_out[0]; p_d1 = write_data_out[1]; p_m = write_lane_mask_out;
      start_in = 1'b0;
      element_valid_in = 1'b0;
      if (e < n_elems) begin
        if (gap_cnt == 0) begin
          element_valid_in = 1'b1; element_in = elems[e];
          elem_edge[e] = cyc + 1; e++; gap_cnt = gap - 1;
        end else begin
          gap_cnt--;
        end
      end
      if (write_enable_out && accepted == stall_pair && stall_left > 0) begin
        rdy = 1'b0; stall_left--;
      end else begin
        rdy = ($urandom_range(99) < ready_pct);
      end
      if (write_enable_out && rdy) begin
        obs_a0.push_back(write_address_out[0]); obs_a1.push_back(write_address_out[1]);
        obs_d0.push_back(write_data_out[0]); obs_d1.push_back(write_data_out[1]);
        obs_m.push_back(write_lane_mask_out);
        accepted++;
      end
      p_rdy = rdy; write_ready_in = rdy;
      @(posedge clock_in);
      cyc++;
    end
    element_valid_in = 1'b0;
    start_in = 1'b0;
  endtask

  task automatic test_reset();
    reset_n_in = 1'b0;
    repeat (2) @(posedge clock_in);
    @(negedge clock_in);
    checks++;
    if ({write_enable_out, write_address_out[0], write_address_out[1], write_data_out[0],
         write_data_out[1], write_lane_mask_out, busy_out, done_out, error_out} !== 31'd0) begin
      errors++;
      $display("FAIL reset_outputs: got wen=%b a=%0d,%0d d=%0d,%0d m=%b busy=%b done=%b err=%b, required all 0",
               write_enable_out, write_address_out[0], write_address_out[1], write_data_out[0],
               write_data_out[1], write_lane_mask_out, busy_out, done_out, error_out);
    end
    reset_n_in = 1'b1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) elems[i] = 8'(i + 1);
    build_expected(4);
    drive_op(5'd4, 9, 1, 100, -1, 0, 1'b0);
    checks++;
    if (timed_out) begin errors++; $display("FAIL b2b_timeout: done never seen, required done"); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (k >= obs_a0.size()) begin
        errors++; $display("FAIL b2b_write%0d: missing, required addr %0d", k, exp_a0[k]);
      end else if (obs_a0[k] !== exp_a0[k] || obs_a1[k] !== exp_a1[k] || obs_d0[k] !== exp_d0[k] ||
                   obs_d1[k] !== exp_d1[k] || obs_m[k] !== exp_m[k]) begin
        errors++;
        $display("FAIL b2b_write%0d: got (%0d,%0d)=(%0d,%0d) m=%b, required (%0d,%0d)=(%0d,%0d) m=%b",
                 k, obs_a0[k], obs_a1[k], obs_d0[k], obs_d1[k], obs_m[k],
                 exp_a0[k], exp_a1[k], exp_d0[k], exp_d1[k], exp_m[k]);
      end
    end
    checks++;
    if (obs_a0.size() != 5) begin errors++; $display("FAIL b2b_count: got %0d writes, required 5", obs_a0.size()); end
    checks++;
    if (done_at != 10 || done_cnt != 1) begin
      errors++; $display("FAIL b2b_done: got done at cycle %0d count %0d, required cycle 10 count 1", done_at, done_cnt);
    end
    checks++;
    if (after_err !== 1'b0 || after_busy !== 1'b0 || after_wen !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got err=%b busy=%b wen=%b, required 0 0 0", after_err, after_busy, after_wen);
    end
    checks++;
    if (rise_q.size() == 0 || rise_q[0] != 2) begin
      errors++; $display("FAIL b2b_first_wen: got %0d, required rise at cycle 2", rise_q.size() ? rise_q[0] : -1);
    end
  endtask

  task automatic test_backpressure(input int ready_pct);
    logic [4:0] base;
    random_elems();
    elems[0] = 8'hFF; elems[1] = 8'h80; elems[2] = 8'h7F; elems[3] = 8'h00;
    base = 5'($urandom_range(31));
    build_expected(base);
    drive_op(base, 9, 1, ready_pct, 1, 3, 1'b0);
    checks++;
    if (timed_out) begin errors++; $display("FAIL bp_timeout: done never seen, required done"); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (k >= obs_a0.size()) begin
        errors++; $display("FAIL bp_write%0d: missing, required addr %0d", k, exp_a0[k]);
      end else if (obs_a0[k] !== exp_a0[k] || obs_a1[k] !== exp_a1[k] || obs_d0[k] !== exp_d0[k] ||
                   obs_d1[k] !== exp_d1[k] || obs_m[k] !== exp_m[k]) begin
        errors++;
        $display("FAIL bp_write%0d: got (%0d,%0d)=(%0d,%0d) m=%b, required (%0d,%0d)=(%0d,%0d) m=%b",
                 k, obs_a0[k], obs_a1[k], obs_d0[k], obs_d1[k], obs_m[k],
                 exp_a0[k], exp_a1[k], exp_d0[k], exp_d1[k], exp_m[k]);
      end
    end
    checks++;
    if (unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stall cycles, required 0", unstable); end
    checks++;
    if (done_cnt != 1 || after_err !== 1'b0) begin
      errors++; $display("FAIL bp_done: got done count %0d err=%b, required 1 and 0", done_cnt, after_err);
    end
  endtask

  task automatic test_gapped();
    random_elems();
    build_expected(9);
    drive_op(5'd9, 9, 4, 100, -1, 0, 1'b0);
    checks++;
    if (rise_q.size() != 5) begin
      errors++; $display("FAIL gap_rises: got %0d enable rises, required 5", rise_q.size());
    end
    for (int k = 0; k < 5 && k < rise_q.size(); k++) begin
      checks++;
      if (rise_q[k] != elem_edge[(k < 4) ? 2 * k + 1 : 8]) begin
        errors++; $display("FAIL gap_rise%0d: got cycle %0d, required %0d", k, rise_q[k], elem_edge[(k < 4) ? 2 * k + 1 : 8]);
      end
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (k >= obs_d0.size() || obs_d0[k] !== exp_d0[k] || obs_d1[k] !== exp_d1[k] || obs_a0[k] !== exp_a0[k]) begin
        errors++; $display("FAIL gap_write%0d: wrong or missing, required a=%0d d=%0d,%0d", k, exp_a0[k], exp_d0[k], exp_d1[k]);
      end
    end
  endtask

  task automatic test_overflow_and_stray();
    random_elems();
    build_expected(17);
    drive_op(5'd17, 10, 1, 100, -1, 0, 1'b0);
    checks++;
    if (after_err !== 1'b1) begin errors++; $display("FAIL ovf_error: got %b, required 1", after_err); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (k >= obs_d0.size() || obs_d0[k] !== exp_d0[k] || obs_d1[k] !== exp_d1[k] ||
          obs_a0[k] !== exp_a0[k] || obs_a1[k] !== exp_a1[k] || obs_m[k] !== exp_m[k]) begin
        errors++; $display("FAIL ovf_write%0d: wrong or missing, required a=%0d d=%0d,%0d", k, exp_a0[k], exp_d0[k], exp_d1[k]);
      end
    end
    repeat (3) @(negedge clock_in);
    checks++;
    if (error_out !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, required 1", error_out); end
    random_elems();
    build_expected(2);
    drive_op(5'd2, 9, 1, 100, -1, 0, 1'b1);
    checks++;
    if (first_err !== 1'b0 || after_err !== 1'b0) begin
      errors++; $display("FAIL start_clears_error: got %b then %b, required 0 then 0", first_err, after_err);
    end
    checks++;
    if (obs_d0.size() != 5 || obs_d0[0] !== exp_d0[0] || obs_d1[0] !== exp_d1[0]) begin
      errors++; $display("FAIL start_valid_ignored: first pair wrong, required d=%0d,%0d", exp_d0[0], exp_d1[0]);
    end
    @(negedge clock_in);
    element_valid_in = 1'b1;
    @(negedge clock_in);
    element_valid_in = 1'b0;
    @(negedge clock_in);
    checks++;
    if (error_out !== 1'b1 || write_enable_out !== 1'b0) begin
      errors++; $display("FAIL stray_valid: got err=%b wen=%b, required 1 0", error_out, write_enable_out);
    end
  endtask

  task automatic test_address_wrap();
    random_elems();
    build_expected(30);
    drive_op(5'd30, 9, 1, 70, -1, 0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (k >= obs_a0.size() || obs_a0[k] !== exp_a0[k] || obs_a1[k] !== exp_a1[k] ||
          obs_m[k] !== exp_m[k] || obs_d0[k] !== exp_d0[k] || obs_d1[k] !== exp_d1[k]) begin
        errors++; $display("FAIL wrap_write%0d: wrong or missing, required a=%0d,%0d m=%b", k, exp_a0[k], exp_a1[k], exp_m[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int e, acc, stalled;
    bit hit;
    random_elems();
    e = 0; acc = 0; stalled = 0; hit = 1'b0;
    @(negedge clock_in);
    start_in = 1'b1; base_address_in = 5'd11; write_ready_in = 1'b1; element_valid_in = 1'b0;
    @(posedge clock_in);
    for (int i = 0; i < 60; i++) begin
      @(negedge clock_in);
      start_in = 1'b0;
      if (write_enable_out && acc == 2) stalled++;
      if (stalled == 2) begin hit = 1'b1; break; end
      element_valid_in = (e < 9);
      if (e < 9) begin element_in = elems[e]; e++; end
      write_ready_in = !(write_enable_out && acc == 2);
      if (write_enable_out && write_ready_in) acc++;
      @(posedge clock_in);
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rstmid_stall: pair 2 stall not reached, required stall"); end
    reset_n_in = 1'b0; element_valid_in = 1'b1;
    @(negedge clock_in);
    reset_n_in = 1'b1; element_valid_in = 1'b0;
    checks++;
    if ({write_enable_out, write_address_out[0], write_address_out[1], write_data_out[0],
         write_data_out[1], write_lane_mask_out, busy_out, done_out, error_out} !== 31'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: got wen=%b a=%0d d=%0d m=%b busy=%b err=%b, required all 0",
               write_enable_out, write_address_out[0], write_data_out[0], write_lane_mask_out, busy_out, error_out);
    end
    random_elems();
    build_expected(20);
    drive_op(5'd20, 9, 2, 80, -1, 0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (k >= obs_a0.size() || obs_a0[k] !== exp_a0[k] || obs_a1[k] !== exp_a1[k] ||
          obs_d0[k] !== exp_d0[k] || obs_d1[k] !== exp_d1[k] || obs_m[k] !== exp_m[k]) begin
        errors++; $display("FAIL rstmid_fresh%0d: wrong or missing, required a=%0d d=%0d,%0d", k, exp_a0[k], exp_d0[k], exp_d1[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure(100);
    test_backpressure(55);
    test_gapped();
    test_overflow_and_stray();
    test_address_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
